// File: rtl/shield_renderer.sv
//------------------------------------------------------------------------------
// shield_renderer : two-stage pipelined shield-bar sprite with a frame-counted
//                   hit flash and a frame-synchronous rotation latch.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shield_renderer #(
  parameter int unsigned LEN          = 32,
  parameter int unsigned THICK        = 4,
  parameter int unsigned GAP          = 20,
  parameter logic [11:0] COLOR        = 12'h0FF,
  parameter logic [11:0] FLASH_COLOR  = 12'hF00,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [1:0]  rotate_in,
  input  logic        hit_in,
  input  logic        enable_in,
  output logic [11:0] pixel_out,
  output logic        in_shield_out,
  output logic        flashing_out
);

  localparam logic signed [12:0] C_HALF  = 13'(LEN / 2);
  localparam logic signed [12:0] C_GAP   = 13'(GAP);
  localparam logic signed [12:0] C_THICK = 13'(THICK);
  localparam logic signed [12:0] C_ONE   = 13'sd1;
  localparam logic [7:0]         C_FLASH_LOAD = 8'(FLASH_FRAMES);

  localparam logic [1:0] ROT_UP    = 2'd0;
  localparam logic [1:0] ROT_RIGHT = 2'd1;
  localparam logic [1:0] ROT_DOWN  = 2'd2;

  logic [1:0]  rot_q, rot_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic        flashing_q, flashing_d;
  logic [3:0]  cmp_q, cmp_d;
  logic        en_s1_q, en_s1_d;
  logic [11:0] pixel_q, pixel_d;
  logic        in_shield_q, in_shield_d;

  logic signed [12:0] w_cx, w_cy, w_h, w_v;
  logic signed [12:0] w_xlo, w_xhi, w_ylo, w_yhi;
  logic               w_hit;

  // Signed 13-bit space lets bounds go negative so bars clip at the screen edge.
  always_comb begin
    w_cx = signed'({2'b00, x_in});
    w_cy = signed'({3'b000, y_in});
    w_h  = signed'({2'b00, hcount_in});
    w_v  = signed'({3'b000, vcount_in});
    w_xlo = w_cx - C_HALF;
    w_xhi = w_cx + C_HALF - C_ONE;
    w_ylo = w_cy - C_GAP - C_THICK;
    w_yhi = w_cy - C_GAP - C_ONE;
    case (rot_q)
      ROT_UP: ;
      ROT_DOWN: begin
        w_ylo = w_cy + C_GAP;
        w_yhi = w_cy + C_GAP + C_THICK - C_ONE;
      end
      ROT_RIGHT: begin
        w_xlo = w_cx + C_GAP;
        w_xhi = w_cx + C_GAP + C_THICK - C_ONE;
        w_ylo = w_cy - C_HALF;
        w_yhi = w_cy + C_HALF - C_ONE;
      end
      default: begin
        w_xlo = w_cx - C_GAP - C_THICK;
        w_xhi = w_cx - C_GAP - C_ONE;
        w_ylo = w_cy - C_HALF;
        w_yhi = w_cy + C_HALF - C_ONE;
      end
    endcase
  end

  always_comb begin
    rot_d = new_frame_in ? rotate_in : rot_q;

    flash_cnt_d = flash_cnt_q;
    if (hit_in) begin
      flash_cnt_d = C_FLASH_LOAD;
    end else if (new_frame_in && (flash_cnt_q != 8'd0)) begin
      flash_cnt_d = flash_cnt_q - 8'd1;
    end
    flashing_d = (flash_cnt_d != 8'd0);

    cmp_d   = {(w_h >= w_xlo), (w_h <= w_xhi), (w_v >= w_ylo), (w_v <= w_yhi)};
    en_s1_d = enable_in;

    w_hit       = (&cmp_q) & en_s1_q;
    in_shield_d = w_hit;
    pixel_d     = 12'h000;
    if (w_hit) begin
      pixel_d = flash_cnt_q[0] ? FLASH_COLOR : COLOR;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rot_q       <= ROT_UP;
      flash_cnt_q <= 8'd0;
      flashing_q  <= 1'b0;
      cmp_q       <= 4'd0;
      en_s1_q     <= 1'b0;
      pixel_q     <= 12'h000;
      in_shield_q <= 1'b0;
    end else begin
      rot_q       <= rot_d;
      flash_cnt_q <= flash_cnt_d;
      flashing_q  <= flashing_d;
      cmp_q       <= cmp_d;
      en_s1_q     <= en_s1_d;
      pixel_q     <= pixel_d;
      in_shield_q <= in_shield_d;
    end
  end

  assign pixel_out     = pixel_q;
  assign in_shield_out = in_shield_q;
  assign flashing_out  = flashing_q;

endmodule

`default_nettype wire
